// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//   Serial-to-parallel frame receiver. Collects WIDTH-bit frames from a strobed
//   1-bit line, MSB- or LSB-first (chosen on each frame's start bit). The shift
//   register and the output buffer are separate, so a new frame can shift in
//   while the previous word waits for the consumer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   s_in       serial data bit
//   s_valid    bit strobe for s_in
//   s_start    with s_valid: this bit is bit 0 of a new frame
//   dir        sampled on the start bit: 0 = MSB-first, 1 = LSB-first
//   p_out      received parallel word (output buffer)
//   p_valid    p_out holds an unconsumed word
//   p_ready    consumer accepts p_out when p_valid && p_ready
//   busy       frame in progress
//   overrun    1-cycle pulse: completed frame dropped because buffer was full
//   frame_err  1-cycle pulse: start bit arrived mid-frame, partial frame lost
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             s_start,
  input  logic             dir,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sr_r;
  logic [CW-1:0]    cnt_r;
  logic             dir_r;

  logic             start_bit_s;
  logic             bit_dir_s;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] shifted_s;
  logic             complete_s;
  logic             transfer_s;

  // Next shift-register value and frame-completion / handshake decode.
  always_comb begin
    start_bit_s = s_valid && s_start;
    // A start bit uses the live dir and shifts into a cleared register,
    // so any partial frame is discarded.
    if (start_bit_s) begin
      bit_dir_s = dir;
      base_s    = '0;
    end else begin
      bit_dir_s = dir_r;
      base_s    = sr_r;
    end
    if (bit_dir_s) begin
      shifted_s = {s_in, base_s[WIDTH-1:1]};
    end else begin
      shifted_s = {base_s[WIDTH-2:0], s_in};
    end
    complete_s = (state_r == SHIFT) && s_valid && !s_start && (cnt_r == CNT_LAST);
    transfer_s = p_valid && p_ready;
  end

  // Frame FSM: shift register, bit counter, latched direction and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sr_r    <= '0;
      cnt_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_bit_s) begin
            dir_r   <= dir;
            sr_r    <= shifted_s;
            cnt_r   <= CNT_ONE;
            state_r <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (start_bit_s) begin
            dir_r <= dir;
            sr_r  <= shifted_s;
            cnt_r <= CNT_ONE;
          end else if (s_valid) begin
            sr_r <= shifted_s;
            if (cnt_r == CNT_LAST) begin
              cnt_r   <= CNT_ZERO;
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Output buffer with valid/ready handshake and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_out     <= '0;
      p_valid   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= (state_r == SHIFT) && start_bit_s;
      if (complete_s) begin
        // Load only if the buffer is empty or being drained this cycle;
        // otherwise keep the old word and drop the new one.
        if (!p_valid || p_ready) begin
          p_out   <= shifted_s;
          p_valid <= 1'b1;
          overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        overrun <= 1'b0;
        if (transfer_s) begin
          p_valid <= 1'b0;
        end
      end
    end
  end

endmodule
